// File: rtl/mc_ctrl_fsm.sv
// Main control FSM for the multicycle MIPS datapath: decodes the opcode, sequences
// the datapath selects and write enables, stalls on mem_ready and counts retired instructions.
module mc_ctrl_fsm #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExec     = 4'd6,
    StRWb      = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StAddiExec = 4'd10,
    StAddiWb   = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             retire;
  logic             pc_write, pc_write_cond, mem_write, ir_write, reg_write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StFetch;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    illegal_d     = 1'b0;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    reg_write     = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    PCSource      = 2'b00;
    unique case (state_q)
      StFetch: begin
        MemRead  = 1'b1;
        ALUSrcB  = 2'b01;
        // PC and IR load only once the fetch completes, so a stall never double-writes
        ir_write = mem_ready;
        pc_write = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OpLw, OpSw: state_d = StMemAddr;
          OpRtype:    state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          OpAddi:     state_d = StAddiExec;
          default: begin
            state_d   = StFetch;
            illegal_d = 1'b1;
          end
        endcase
      end
      StMemAddr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (opcode == OpLw) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        reg_write = 1'b1;
        MemtoReg  = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StMemWrite: begin
        mem_write = 1'b1;
        IorD      = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = StFetch;
        end
      end
      StExec: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = StRWb;
      end
      StRWb: begin
        reg_write = 1'b1;
        RegDst    = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        ALUSrcA       = 1'b1;
        ALUOp         = 2'b01;
        pc_write_cond = 1'b1;
        PCSource      = 2'b01;
        retire        = 1'b1;
        state_d       = StFetch;
      end
      StJump: begin
        pc_write = 1'b1;
        PCSource = 2'b10;
        retire   = 1'b1;
        state_d  = StFetch;
      end
      StAddiExec: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = StAddiWb;
      end
      StAddiWb: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      default: state_d = StFetch;
    endcase
    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Write enables drop combinationally while reset is held
  assign PCWrite     = pc_write & rst;
  assign PCWriteCond = pc_write_cond & rst;
  assign MemWrite    = mem_write & rst;
  assign IRWrite     = ir_write & rst;
  assign RegWrite    = reg_write & rst;

  assign state     = state_q;
  assign illegal   = illegal_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-cycle vector table fed through a scoreboard,
// plus a hand-written mid-instruction reset sequence and a counter wrap check.
module tb_mc_ctrl_fsm;

  localparam int unsigned CntW = 4;
  localparam logic [5:0] OpR = 6'b000000, OpLw = 6'b100011, OpSw = 6'b101011;
  localparam logic [5:0] OpBeq = 6'b000100, OpJ = 6'b000010, OpAddi = 6'b001000;
  localparam logic [5:0] OpBad = 6'b111111;

  typedef struct {
    logic            rst;
    logic [5:0]      op;
    logic            mr;
    logic [3:0]      st;
    logic [CntW-1:0] cnt;
    logic            ill;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [5:0] opcode = OpLw;
  logic mem_ready = 1'b1;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite;
  logic ALUSrcA, illegal;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic [CntW-1:0] instr_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[$];
  vec_t sb[$];

  mc_ctrl_fsm #(.CNT_W(CntW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .illegal(illegal), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  wire [15:0] dut_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                          RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  // Reference output table, same bit order as dut_ctrl
  function automatic logic [15:0] ref_ctrl(input logic [3:0] st, input logic mr, input logic rs);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, aop, psrc;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa} = '0;
    {asb, aop, psrc} = '0;
    case (st)
      4'd0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mwr = 1; iord = 1; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rdst = 1; end
      4'd8:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
      4'd9:  begin pcw = 1; psrc = 2'b10; end
      4'd10: begin asa = 1; asb = 2'b10; end
      4'd11: rw = 1;
      default: ;
    endcase
    if (!rs) {pcw, pcwc, irw, mwr, rw} = '0;
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic [5:0] op, input logic mr, input logic [3:0] st,
                     input int cnt, input logic ill);
    vec_t v;
    v.rst = r; v.op = op; v.mr = mr; v.st = st; v.cnt = CntW'(cnt); v.ill = ill;
    vecs.push_back(v);
  endtask

  task automatic run_vecs();
    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst;
      opcode = vecs[i].op;
      mem_ready = vecs[i].mr;
      sb.push_back(vecs[i]);
    end
    @(negedge clk);
    #3;
    vecs.delete();
  endtask

  // Scoreboard checker: compares each driven cycle mid-way through the low phase
  always @(negedge clk) begin
    #2;
    if (sb.size() > 0) begin
      vec_t v;
      v = sb.pop_front();
      check($sformatf("state st%0d", v.st), 16'(state), 16'(v.st));
      check($sformatf("ctrl st%0d", v.st), dut_ctrl, ref_ctrl(v.st, v.mr, v.rst));
      check($sformatf("instr_cnt st%0d", v.st), 16'(instr_cnt), 16'(v.cnt));
      check($sformatf("illegal st%0d", v.st), 16'(illegal), 16'(v.ill));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held three cycles, then lw with mem_ready always high
    repeat (3) add(0, OpLw, 1, 0, 0, 0);
    add(1, OpLw, 1, 0, 0, 0); add(1, OpLw, 1, 1, 0, 0); add(1, OpLw, 1, 2, 0, 0);
    add(1, OpLw, 1, 3, 0, 0); add(1, OpLw, 1, 4, 0, 0);
    // sw with two stall cycles in MEM_WRITE
    add(1, OpSw, 1, 0, 1, 0); add(1, OpSw, 1, 1, 1, 0); add(1, OpSw, 1, 2, 1, 0);
    add(1, OpSw, 0, 5, 1, 0); add(1, OpSw, 0, 5, 1, 0); add(1, OpSw, 1, 5, 1, 0);
    // R-type, addi, beq (mem_ready low where it must be ignored), j
    add(1, OpR, 1, 0, 2, 0); add(1, OpR, 1, 1, 2, 0); add(1, OpR, 1, 6, 2, 0);
    add(1, OpR, 1, 7, 2, 0);
    add(1, OpAddi, 1, 0, 3, 0); add(1, OpAddi, 1, 1, 3, 0); add(1, OpAddi, 1, 10, 3, 0);
    add(1, OpAddi, 1, 11, 3, 0);
    add(1, OpBeq, 1, 0, 4, 0); add(1, OpBeq, 0, 1, 4, 0); add(1, OpBeq, 0, 8, 4, 0);
    add(1, OpJ, 1, 0, 5, 0); add(1, OpJ, 1, 1, 5, 0); add(1, OpJ, 1, 9, 5, 0);
    // Illegal opcode, then a stalled fetch of the next R-type
    add(1, OpBad, 1, 0, 6, 0); add(1, OpBad, 1, 1, 6, 0);
    add(1, OpR, 0, 0, 6, 1); add(1, OpR, 0, 0, 6, 0); add(1, OpR, 1, 0, 6, 0);
    add(1, OpR, 1, 1, 6, 0); add(1, OpR, 1, 6, 6, 0);
    run_vecs();

    // In R_WB now; drop reset mid-cycle
    check("rwb state", 16'(state), 16'd7);
    check("rwb RegWrite", 16'(RegWrite), 16'd1);
    check("rwb RegDst", 16'(RegDst), 16'd1);
    rst = 1'b0;
    #1;
    check("async reset state", 16'(state), 16'd0);
    check("async reset RegWrite", 16'(RegWrite), 16'd0);
    check("async reset instr_cnt", 16'(instr_cnt), 16'd0);

    // Sixteen jumps: count reaches 15, then wraps to 0
    add(0, OpJ, 1, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      add(1, OpJ, 1, 0, k, 0); add(1, OpJ, 1, 1, k, 0); add(1, OpJ, 1, 9, k, 0);
    end
    add(1, OpJ, 1, 0, 0, 0);
    run_vecs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
